// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode encodings and payload types for the reservation station.
// Also holds the CDB operand-capture rule used by both issue bypass and snoop.
package reservation_station_pkg;

    localparam int unsigned RS_SIZE  = 16;
    localparam int unsigned ROB_W    = 6;
    localparam int unsigned RS_IDX_W = $clog2(RS_SIZE);
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned XLEN     = 32;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'd3;
    localparam logic [OPCODE_W-1:0] OP_AND  = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_OR   = 6'd5;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 6'd6;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'd7;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 6'd8;
    localparam logic [OPCODE_W-1:0] OP_SLT  = 6'd9;

    typedef struct packed {
        logic             busy;
        logic [ROB_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } operand_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        operand_t            src1;
        operand_t            src2;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     pc;
        logic [ROB_W-1:0]    rob_index;
    } rs_entry_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [XLEN-1:0]     val1;
        logic [XLEN-1:0]     val2;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     pc;
        logic [ROB_W-1:0]    rob_index;
    } alu_req_t;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] rob_index;
        logic [XLEN-1:0]  res;
    } cdb_t;

    // Waiting operand captures a matching broadcast; ALU takes precedence over LSB.
    function automatic operand_t snoop_operand(operand_t op, cdb_t alu, cdb_t lsb);
        operand_t r;
        r = op;
        if (op.busy) begin
            if (alu.valid && (alu.rob_index == op.tag)) begin
                r.busy = 1'b0;
                r.val  = alu.res;
            end else if (lsb.valid && (lsb.rob_index == op.tag)) begin
                r.busy = 1'b0;
                r.val  = lsb.res;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatcher issue port, CDB snoop inputs and ALU request outputs of the reservation station.
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic                issue_valid;
    logic [OPCODE_W-1:0] issue_opcode;
    logic                issue_qj_busy;
    logic [ROB_W-1:0]    issue_qj;
    logic [XLEN-1:0]     issue_vj;
    logic                issue_qk_busy;
    logic [ROB_W-1:0]    issue_qk;
    logic [XLEN-1:0]     issue_vk;
    logic [XLEN-1:0]     issue_imm;
    logic [XLEN-1:0]     issue_pc;
    logic [ROB_W-1:0]    issue_rob_index;
    logic                full;

    logic                alu_cdb_valid;
    logic [ROB_W-1:0]    alu_cdb_rob_index;
    logic [XLEN-1:0]     alu_cdb_res;
    logic                lsb_cdb_valid;
    logic [ROB_W-1:0]    lsb_cdb_rob_index;
    logic [XLEN-1:0]     lsb_cdb_res;

    logic [OPCODE_W-1:0] alu_opcode;
    logic [XLEN-1:0]     alu_val1;
    logic [XLEN-1:0]     alu_val2;
    logic [XLEN-1:0]     alu_imm;
    logic [XLEN-1:0]     alu_pc;
    logic [ROB_W-1:0]    alu_rob_index;

    modport master (
        output issue_valid, issue_opcode, issue_qj_busy, issue_qj, issue_vj,
               issue_qk_busy, issue_qk, issue_vk, issue_imm, issue_pc, issue_rob_index,
               alu_cdb_valid, alu_cdb_rob_index, alu_cdb_res,
               lsb_cdb_valid, lsb_cdb_rob_index, lsb_cdb_res,
        input  full, alu_opcode, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_index
    );

    modport slave (
        input  issue_valid, issue_opcode, issue_qj_busy, issue_qj, issue_vj,
               issue_qk_busy, issue_qk, issue_vk, issue_imm, issue_pc, issue_rob_index,
               alu_cdb_valid, alu_cdb_rob_index, alu_cdb_res,
               lsb_cdb_valid, lsb_cdb_rob_index, lsb_cdb_res,
        output full, alu_opcode, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_index
    );

endinterface

// File: rtl/reservation_station_rs_priority_encoder.sv
// Lowest-set-bit finder: index of the first asserted request plus an any-set flag.
module rs_priority_encoder #(
    parameter int unsigned N = 16,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx_c,
    output logic         found_c
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        idx_c   = '0;
        found_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c   = W'(i);
                found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: buffers ops until operands resolve via CDB snoop,
// then dispatches the lowest-index ready op per cycle onto registered ALU outputs.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    reservation_station_if.slave rs
);

    rs_entry_t            ent_q   [RS_SIZE];
    rs_entry_t            ent_nxt [RS_SIZE];
    logic [RS_SIZE-1:0]   busy_q;
    logic [RS_SIZE-1:0]   busy_nxt;
    logic [RS_SIZE-1:0]   ready_vec;
    alu_req_t             alu_q;
    alu_req_t             alu_nxt;

    logic [RS_IDX_W-1:0]  free_idx;
    logic                 free_found;
    logic [RS_IDX_W-1:0]  disp_idx;
    logic                 disp_found;

    cdb_t                 alu_cdb;
    cdb_t                 lsb_cdb;
    operand_t             issue_src1;
    operand_t             issue_src2;
    rs_entry_t            issue_ent;

    assign alu_cdb = '{valid: rs.alu_cdb_valid, rob_index: rs.alu_cdb_rob_index, res: rs.alu_cdb_res};
    assign lsb_cdb = '{valid: rs.lsb_cdb_valid, rob_index: rs.lsb_cdb_rob_index, res: rs.lsb_cdb_res};

    assign rs.full = &busy_q;

    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy_q[i] & ~ent_q[i].src1.busy & ~ent_q[i].src2.busy;
        end
    end

    rs_priority_encoder #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_pe (
        .req     (~busy_q),
        .idx_c   (free_idx),
        .found_c (free_found)
    );

    rs_priority_encoder #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_pe (
        .req     (ready_vec),
        .idx_c   (disp_idx),
        .found_c (disp_found)
    );

    // Incoming op with same-cycle CDB bypass applied to its operands.
    always_comb begin
        issue_src1.busy = rs.issue_qj_busy;
        issue_src1.tag  = rs.issue_qj;
        issue_src1.val  = rs.issue_vj;
        issue_src2.busy = rs.issue_qk_busy;
        issue_src2.tag  = rs.issue_qk;
        issue_src2.val  = rs.issue_vk;
        issue_ent.opcode    = rs.issue_opcode;
        issue_ent.src1      = snoop_operand(issue_src1, alu_cdb, lsb_cdb);
        issue_ent.src2      = snoop_operand(issue_src2, alu_cdb, lsb_cdb);
        issue_ent.imm       = rs.issue_imm;
        issue_ent.pc        = rs.issue_pc;
        issue_ent.rob_index = rs.issue_rob_index;
    end

    // Next state: flush > stall > snoop/dispatch/issue.
    always_comb begin
        ent_nxt  = ent_q;
        busy_nxt = busy_q;
        alu_nxt  = alu_q;
        if (flush) begin
            busy_nxt       = '0;
            alu_nxt.opcode = OP_NOP;
        end else if (!rdy_in) begin
            alu_nxt.opcode = OP_NOP;
        end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    ent_nxt[i].src1 = snoop_operand(ent_q[i].src1, alu_cdb, lsb_cdb);
                    ent_nxt[i].src2 = snoop_operand(ent_q[i].src2, alu_cdb, lsb_cdb);
                end
            end
            if (disp_found) begin
                alu_nxt.opcode    = ent_q[disp_idx].opcode;
                alu_nxt.val1      = ent_q[disp_idx].src1.val;
                alu_nxt.val2      = ent_q[disp_idx].src2.val;
                alu_nxt.imm       = ent_q[disp_idx].imm;
                alu_nxt.pc        = ent_q[disp_idx].pc;
                alu_nxt.rob_index = ent_q[disp_idx].rob_index;
                busy_nxt[disp_idx] = 1'b0;
            end else begin
                alu_nxt.opcode = OP_NOP;
            end
            // Free slot is never the dispatching slot, so the two updates do not collide.
            if (rs.issue_valid && free_found) begin
                ent_nxt[free_idx]  = issue_ent;
                busy_nxt[free_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q <= '0;
            alu_q  <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_nxt;
            alu_q  <= alu_nxt;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= ent_nxt[i];
            end
        end
    end

    assign rs.alu_opcode    = alu_q.opcode;
    assign rs.alu_val1      = alu_q.val1;
    assign rs.alu_val2      = alu_q.val2;
    assign rs.alu_imm       = alu_q.imm;
    assign rs.alu_pc        = alu_q.pc;
    assign rs.alu_rob_index = alu_q.rob_index;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic against a
// slot-list reference model that tracks which ops wait on which tags.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic flush = 1'b0;

    reservation_station_if rs_if ();

    reservation_station dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .flush  (flush),
        .rs     (rs_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        busy;
        bit [5:0]  op;
        bit        jb;
        bit [5:0]  jt;
        bit [31:0] jv;
        bit        kb;
        bit [5:0]  kt;
        bit [31:0] kv;
        bit [31:0] imm;
        bit [31:0] pc;
        bit [5:0]  rob;
    } slot_t;

    typedef struct {
        bit        waiting;
        bit [31:0] v;
    } opv_t;

    slot_t     m [16];
    bit [5:0]  exp_op;
    bit [31:0] exp_v1, exp_v2, exp_imm, exp_pc;
    bit [5:0]  exp_rob;
    int        total = 0;
    int        bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // A waiting operand picks up the broadcast carrying its tag, ALU before LSB.
    function automatic opv_t capture(bit waiting, bit [5:0] t, bit [31:0] v);
        opv_t r;
        r.waiting = waiting;
        r.v = v;
        if (waiting && rs_if.alu_cdb_valid && rs_if.alu_cdb_rob_index == t) begin
            r.waiting = 1'b0; r.v = rs_if.alu_cdb_res;
        end else if (waiting && rs_if.lsb_cdb_valid && rs_if.lsb_cdb_rob_index == t) begin
            r.waiting = 1'b0; r.v = rs_if.lsb_cdb_res;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
        exp_op = 0; exp_v1 = 0; exp_v2 = 0; exp_imm = 0; exp_pc = 0; exp_rob = 0;
    endtask

    // Effect of one clock edge given the inputs currently applied.
    task automatic model_edge();
        slot_t n [16];
        opv_t  a, b;
        int    d = -1;
        int    f = -1;
        if (flush) begin
            for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
            exp_op = 0;
        end else if (!rdy) begin
            exp_op = 0;
        end else begin
            n = m;
            for (int i = 0; i < 16; i++) begin
                if (d < 0 && m[i].busy && !m[i].jb && !m[i].kb) d = i;
                if (f < 0 && !m[i].busy) f = i;
                if (m[i].busy) begin
                    a = capture(m[i].jb, m[i].jt, m[i].jv);
                    b = capture(m[i].kb, m[i].kt, m[i].kv);
                    n[i].jb = a.waiting; n[i].jv = a.v;
                    n[i].kb = b.waiting; n[i].kv = b.v;
                end
            end
            if (d >= 0) begin
                exp_op = m[d].op; exp_v1 = m[d].jv; exp_v2 = m[d].kv;
                exp_imm = m[d].imm; exp_pc = m[d].pc; exp_rob = m[d].rob;
                n[d].busy = 1'b0;
            end else begin
                exp_op = 0;
            end
            if (rs_if.issue_valid && f >= 0) begin
                a = capture(rs_if.issue_qj_busy, rs_if.issue_qj, rs_if.issue_vj);
                b = capture(rs_if.issue_qk_busy, rs_if.issue_qk, rs_if.issue_vk);
                n[f].busy = 1'b1;
                n[f].op = rs_if.issue_opcode;
                n[f].jb = a.waiting; n[f].jt = rs_if.issue_qj; n[f].jv = a.v;
                n[f].kb = b.waiting; n[f].kt = rs_if.issue_qk; n[f].kv = b.v;
                n[f].imm = rs_if.issue_imm; n[f].pc = rs_if.issue_pc;
                n[f].rob = rs_if.issue_rob_index;
            end
            m = n;
        end
    endtask

    function automatic bit model_full();
        for (int i = 0; i < 16; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".full"}, 32'(rs_if.full), 32'(model_full()));
        check({tag, ".opcode"}, 32'(rs_if.alu_opcode), 32'(exp_op));
        check({tag, ".val1"}, rs_if.alu_val1, exp_v1);
        check({tag, ".val2"}, rs_if.alu_val2, exp_v2);
        check({tag, ".imm"}, rs_if.alu_imm, exp_imm);
        check({tag, ".pc"}, rs_if.alu_pc, exp_pc);
        check({tag, ".rob"}, 32'(rs_if.alu_rob_index), 32'(exp_rob));
    endtask

    task automatic idle_inputs();
        rs_if.issue_valid = 0; rs_if.issue_opcode = 0;
        rs_if.issue_qj_busy = 0; rs_if.issue_qj = 0; rs_if.issue_vj = 0;
        rs_if.issue_qk_busy = 0; rs_if.issue_qk = 0; rs_if.issue_vk = 0;
        rs_if.issue_imm = 0; rs_if.issue_pc = 0; rs_if.issue_rob_index = 0;
        rs_if.alu_cdb_valid = 0; rs_if.alu_cdb_rob_index = 0; rs_if.alu_cdb_res = 0;
        rs_if.lsb_cdb_valid = 0; rs_if.lsb_cdb_rob_index = 0; rs_if.lsb_cdb_res = 0;
        flush = 0; rdy = 1;
    endtask

    task automatic issue(input bit [5:0] op, input bit jb, input bit [5:0] jt, input bit [31:0] jv,
                         input bit kb, input bit [5:0] kt, input bit [31:0] kv,
                         input bit [31:0] imm, input bit [31:0] pc, input bit [5:0] rob);
        rs_if.issue_valid = 1; rs_if.issue_opcode = op;
        rs_if.issue_qj_busy = jb; rs_if.issue_qj = jt; rs_if.issue_vj = jv;
        rs_if.issue_qk_busy = kb; rs_if.issue_qk = kt; rs_if.issue_vk = kv;
        rs_if.issue_imm = imm; rs_if.issue_pc = pc; rs_if.issue_rob_index = rob;
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 0;
        tick("idle");

        // Both operands ready: visible one edge after issue, then idle.
        issue(OP_ADD, 0, 0, 3, 0, 0, 4, 0, 32'h100, 6'd11);
        tick("add_issue");
        tick("add_disp");
        check("add_val1", rs_if.alu_val1, 32'd3);
        tick("add_idle");

        // src1 waits on tag 5 until the ALU broadcasts it.
        issue(OP_SUB, 1, 6'd5, 0, 0, 0, 32'd1, 0, 32'h104, 6'd12);
        tick("sub_issue");
        tick("sub_wait");
        rs_if.alu_cdb_valid = 1; rs_if.alu_cdb_rob_index = 6'd5; rs_if.alu_cdb_res = 32'd10;
        tick("sub_cdb");
        tick("sub_disp");
        check("sub_val1", rs_if.alu_val1, 32'd10);

        // Same-cycle LSB bypass on issue.
        issue(OP_ADDI, 1, 6'd7, 0, 0, 0, 0, 32'd8, 32'h108, 6'd0);
        rs_if.lsb_cdb_valid = 1; rs_if.lsb_cdb_rob_index = 6'd7; rs_if.lsb_cdb_res = 32'hFFFF_FFFF;
        tick("bypass_issue");
        tick("bypass_disp");

        // ALU wins when both buses carry the same tag.
        issue(OP_OR, 1, 6'd3, 0, 0, 0, 0, 0, 32'h10c, 6'd13);
        rs_if.alu_cdb_valid = 1; rs_if.alu_cdb_rob_index = 6'd3; rs_if.alu_cdb_res = 32'hAAAA;
        rs_if.lsb_cdb_valid = 1; rs_if.lsb_cdb_rob_index = 6'd3; rs_if.lsb_cdb_res = 32'h5555;
        tick("prio_issue");
        tick("prio_disp");

        // Fill all slots on tag 9, overflow issue ignored, then drain in index order.
        for (int i = 0; i < 16; i++) begin
            issue(OP_XOR, 1, 6'd9, 0, 0, 0, 32'(i), 0, 32'(i * 4), 6'(i + 32));
            tick("fill");
        end
        check("full_set", 32'(rs_if.full), 32'd1);
        issue(OP_AND, 0, 0, 1, 0, 0, 2, 0, 0, 6'd63);
        tick("overflow");
        rs_if.alu_cdb_valid = 1; rs_if.alu_cdb_rob_index = 6'd9; rs_if.alu_cdb_res = 32'd99;
        tick("drain_cdb");
        for (int i = 0; i < 17; i++) tick("drain");

        // Stall with a ready entry: nothing dispatches, payload holds.
        issue(OP_SLT, 0, 0, 5, 0, 0, 6, 0, 32'h200, 6'd20);
        tick("stall_issue");
        rdy = 0;
        tick("stall");
        tick("stall_release");

        // Flush three ready entries plus a simultaneous issue.
        for (int i = 0; i < 3; i++) begin
            issue(OP_BEQ, 1, 6'd12, 0, 0, 0, 0, 0, 32'h300, 6'(i + 1));
            tick("fl_fill");
        end
        rs_if.alu_cdb_valid = 1; rs_if.alu_cdb_rob_index = 6'd12; rs_if.alu_cdb_res = 32'd7;
        tick("fl_ready");
        issue(OP_BNE, 0, 0, 1, 0, 0, 1, 0, 32'h400, 6'd30);
        flush = 1;
        tick("flush");
        tick("flush_after");
        issue(OP_ADD, 0, 0, 9, 0, 0, 9, 0, 32'h500, 6'd31);
        tick("post_flush_issue");
        tick("post_flush_disp");

        // Asynchronous reset between edges with five waiting entries.
        for (int i = 0; i < 5; i++) begin
            issue(OP_SUB, 1, 6'd20, 0, 0, 0, 0, 0, 0, 6'(i + 40));
            tick("ar_fill");
        end
        #3;
        rst = 1;
        #1;
        model_reset();
        check("async_full", 32'(rs_if.full), 32'd0);
        check("async_op", 32'(rs_if.alu_opcode), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        compare_all("async_hold");
        rs_if.alu_cdb_valid = 1; rs_if.alu_cdb_rob_index = 6'd20; rs_if.alu_cdb_res = 32'd1;
        tick("async_cdb");
        repeat (3) tick("async_quiet");

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 1) == 0)
                issue(6'($urandom_range(1, 9)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                      $urandom, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom, 6'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                rs_if.alu_cdb_valid = 1; rs_if.alu_cdb_rob_index = 6'($urandom_range(0, 7));
                rs_if.alu_cdb_res = $urandom;
            end
            if ($urandom_range(0, 2) == 0) begin
                rs_if.lsb_cdb_valid = 1; rs_if.lsb_cdb_rob_index = 6'($urandom_range(0, 7));
                rs_if.lsb_cdb_res = $urandom;
            end
            if ($urandom_range(0, 9) == 0) rdy = 0;
            if ($urandom_range(0, 59) == 0) flush = 1;
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
